// File: rtl/fr_access_arbiter_pkg.sv
// Shared types and constants for the file-register access arbiter.
package fr_access_arbiter_pkg;

  localparam int unsigned FR_ADDR_W    = 5;
  localparam int unsigned FR_DATA_W    = 8;
  localparam int unsigned FR_MAX_BURST = 4;
  localparam int unsigned BURST_W      = 4;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    EXT_ACC = 2'd1,
    EXT_ACK = 2'd2
  } state_t;

endpackage

// File: rtl/fr_access_arbiter_if.sv
// External-master request/acknowledge channel into the FR arbiter.
interface fr_access_arbiter_if
  import fr_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = FR_ADDR_W,
  parameter int unsigned DATA_W = FR_DATA_W
) ();

  logic              i_ext_req;
  logic              i_ext_we;
  logic [ADDR_W-1:0] i_ext_addr;
  logic [DATA_W-1:0] i_ext_wdata;
  logic              o_ext_ack;
  logic [DATA_W-1:0] o_ext_rdata;

  modport slave (
    input  i_ext_req, i_ext_we, i_ext_addr, i_ext_wdata,
    output o_ext_ack, o_ext_rdata
  );

  modport master (
    output i_ext_req, i_ext_we, i_ext_addr, i_ext_wdata,
    input  o_ext_ack, o_ext_rdata
  );

endinterface

// File: rtl/fr_access_arbiter_fr_port_mux.sv
// Combinational CPU/external source select for the FR port.
module fr_access_arbiter_fr_port_mux
  import fr_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = FR_ADDR_W,
  parameter int unsigned DATA_W = FR_DATA_W
) (
  input  logic              ext_sel,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              fr_re_c,
  output logic              fr_we_c,
  output logic [ADDR_W-1:0] fr_addr_c,
  output logic [DATA_W-1:0] fr_wdata_c
);

  always_comb begin
    fr_re_c    = cpu_re;
    fr_we_c    = cpu_we;
    fr_addr_c  = cpu_addr;
    fr_wdata_c = cpu_wdata;
    if (ext_sel) begin
      fr_re_c    = !ext_we;
      fr_we_c    = ext_we;
      fr_addr_c  = ext_addr;
      fr_wdata_c = ext_wdata;
    end
  end

endmodule

// File: rtl/fr_access_arbiter.sv
// Shares the single-port FR between the CPU and one external master, stalling
// the CPU only at instruction boundaries and bounding external bursts.
module fr_access_arbiter
  import fr_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = FR_ADDR_W,
  parameter int unsigned DATA_W    = FR_DATA_W,
  parameter int unsigned MAX_BURST = FR_MAX_BURST
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_boundary,
  input  logic              i_cpu_FRr,
  input  logic              i_cpu_FRw,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  fr_access_arbiter_if.slave ext,
  output logic              o_cpu_en,
  output logic              o_fr_re,
  output logic              o_fr_we,
  output logic [ADDR_W-1:0] o_fr_addr,
  output logic [DATA_W-1:0] o_fr_wdata,
  input  logic [DATA_W-1:0] i_fr_rdata
);

  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);

  state_t               state_q, state_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                 grant_now_c;
  logic                 mux_re_c, mux_we_c;
  logic [ADDR_W-1:0]    mux_addr_c;
  logic [DATA_W-1:0]    mux_wdata_c;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= CPU_OWN;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Grant drops o_cpu_en in the same cycle so the control unit stays in select.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    grant_now_c = !i_rst && (state_q == CPU_OWN) && ext.i_ext_req &&
                  i_cpu_boundary && (burst_cnt_q < BURST_LIMIT);
    o_cpu_en    = (state_q == CPU_OWN) && !grant_now_c;
    case (state_q)
      CPU_OWN: if (grant_now_c) state_d = EXT_ACC;
      EXT_ACC: state_d = EXT_ACK;
      EXT_ACK: begin
        state_d = CPU_OWN;
        if (burst_cnt_q != '1) burst_cnt_d = burst_cnt_q + BURST_W'(1);
      end
      default: state_d = CPU_OWN;
    endcase
    // Any executed instruction cycle restores the external burst allowance.
    if (o_cpu_en && !i_cpu_boundary) burst_cnt_d = '0;
  end

  fr_access_arbiter_fr_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fr_port_mux (
    .ext_sel    (state_q != CPU_OWN),
    .cpu_re     (i_cpu_FRr),
    .cpu_we     (i_cpu_FRw),
    .cpu_addr   (i_cpu_addr),
    .cpu_wdata  (i_cpu_wdata),
    .ext_we     (ext.i_ext_we),
    .ext_addr   (ext.i_ext_addr),
    .ext_wdata  (ext.i_ext_wdata),
    .fr_re_c    (mux_re_c),
    .fr_we_c    (mux_we_c),
    .fr_addr_c  (mux_addr_c),
    .fr_wdata_c (mux_wdata_c)
  );

  // FR strobes are silent in the ack cycle and everything is quiet in reset.
  always_comb begin
    o_fr_re         = mux_re_c && !i_rst && (state_q != EXT_ACK);
    o_fr_we         = mux_we_c && !i_rst && (state_q != EXT_ACK);
    o_fr_addr       = i_rst ? '0 : mux_addr_c;
    o_fr_wdata      = i_rst ? '0 : mux_wdata_c;
    ext.o_ext_ack   = !i_rst && (state_q == EXT_ACK);
    ext.o_ext_rdata = (ext.o_ext_ack && !ext.i_ext_we) ? i_fr_rdata : '0;
  end

endmodule

// File: tb/tb_fr_access_arbiter.sv
// Randomized and directed checks of fr_access_arbiter against a cycle-count model.
module tb_fr_access_arbiter;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 8;
  localparam int          MAXB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          boundary, cpu_r, cpu_w;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          cpu_en, fr_re, fr_we;
  logic [AW-1:0] fr_addr;
  logic [DW-1:0] fr_wdata;
  logic [DW-1:0] fr_rdata;

  fr_access_arbiter_if ext_if ();
  assign ext_if.i_ext_req   = ext_req;
  assign ext_if.i_ext_we    = ext_we;
  assign ext_if.i_ext_addr  = ext_addr;
  assign ext_if.i_ext_wdata = ext_wdata;

  fr_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cpu_boundary (boundary),
    .i_cpu_FRr      (cpu_r),
    .i_cpu_FRw      (cpu_w),
    .i_cpu_addr     (cpu_addr),
    .i_cpu_wdata    (cpu_wdata),
    .ext            (ext_if),
    .o_cpu_en       (cpu_en),
    .o_fr_re        (fr_re),
    .o_fr_we        (fr_we),
    .o_fr_addr      (fr_addr),
    .o_fr_wdata     (fr_wdata),
    .i_fr_rdata     (fr_rdata)
  );

  // FR storage driven by the DUT; reloaded from the reference image in reset.
  logic [DW-1:0] env_mem [32];
  logic [DW-1:0] ref_mem [32];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 32; i++) env_mem[i] <= ref_mem[i];
    else if (fr_we) env_mem[fr_addr] <= fr_wdata;
    if (fr_re) fr_rdata <= env_mem[fr_addr];
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Model: age = cycles since the external grant (-1 = CPU owns the FR).
  int            age   = -1;
  int            burst = 0;
  bit            e_cpu_en, e_ack;
  logic          s_cpu_en, s_ack, s_fr_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata, s_frd;

  task automatic cycle();
    bit            own, g, e_re, e_we, c_addr, c_wd, c_rd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    @(negedge clk);
    own = (age < 0);
    g   = !rst && own && ext_req && boundary && (burst < MAXB);
    e_rdata = '0; c_addr = 1; c_wd = 1; c_rd = 0;
    if (rst) begin
      e_cpu_en = 1; e_ack = 0; e_re = 0; e_we = 0; e_addr = '0; e_wdata = '0; c_rd = 1;
    end else if (own) begin
      e_cpu_en = !g; e_ack = 0; e_re = cpu_r; e_we = cpu_w; e_addr = cpu_addr; e_wdata = cpu_wdata;
    end else if (age == 1) begin
      e_cpu_en = 0; e_ack = 0; e_re = !ext_we; e_we = ext_we; e_addr = ext_addr;
      e_wdata = ext_wdata; c_wd = ext_we;
    end else begin
      e_cpu_en = 0; e_ack = 1; e_re = 0; e_we = 0; e_addr = ext_addr; e_wdata = '0;
      c_addr = 0; c_wd = 0; c_rd = 1;
      e_rdata = ext_we ? '0 : ref_mem[ext_addr];
    end
    s_cpu_en = cpu_en; s_ack = ext_if.o_ext_ack; s_fr_we = fr_we;
    s_addr = fr_addr; s_wdata = fr_wdata; s_rdata = ext_if.o_ext_rdata; s_frd = fr_rdata;
    check_val("cpu_en", 32'(cpu_en), 32'(e_cpu_en));
    check_val("ext_ack", 32'(ext_if.o_ext_ack), 32'(e_ack));
    check_val("fr_re", 32'(fr_re), 32'(e_re));
    check_val("fr_we", 32'(fr_we), 32'(e_we));
    if (c_addr) check_val("fr_addr", 32'(fr_addr), 32'(e_addr));
    if (c_wd) check_val("fr_wdata", 32'(fr_wdata), 32'(e_wdata));
    if (c_rd) check_val("ext_rdata", 32'(ext_if.o_ext_rdata), 32'(e_rdata));
    @(posedge clk);
    if (rst) begin
      age = -1; burst = 0;
    end else begin
      if (e_we) ref_mem[e_addr] = e_wdata;
      if (e_cpu_en && !boundary) burst = 0;
      if (g) age = 1;
      else if (age == 1) age = 2;
      else if (age == 2) begin
        age = -1;
        if (burst < 15) burst++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_cpu(input bit b, input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    boundary = b; cpu_r = r; cpu_w = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ext(input bit q, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ext_req = q; ext_we = we; ext_addr = a; ext_wdata = d;
  endtask

  int            acks, n_we, cpu_left, r;
  logic [AW-1:0] we_addr;

  initial begin
    set_cpu(1, 0, 0, '0, '0);
    set_ext(0, 0, '0, '0);
    for (int i = 0; i < 32; i++) ref_mem[i] = DW'($urandom);
    #1 rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;

    // Idle pass-through of a CPU write
    set_cpu(0, 0, 1, 5'h1F, 8'h11);
    cycle();
    check_val("idle_we", 32'(s_fr_we), 32'h1);
    check_val("idle_addr", 32'(s_addr), 32'h1F);
    check_val("idle_wdata", 32'(s_wdata), 32'h11);
    check_val("idle_cpu_en", 32'(s_cpu_en), 32'h1);

    // External read of 0x0A after the CPU stores 0x3C there
    set_cpu(0, 0, 1, 5'h0A, 8'h3C);
    cycle();
    set_cpu(1, 0, 0, '0, '0);
    set_ext(1, 0, 5'h0A, '0);
    cycle();
    check_val("rd_grant_cpu_en", 32'(s_cpu_en), 32'h0);
    cycle();
    check_val("rd_no_early_ack", 32'(s_ack), 32'h0);
    cycle();
    check_val("rd_ack", 32'(s_ack), 32'h1);
    check_val("rd_data", 32'(s_rdata), 32'h3C);
    set_ext(0, 0, '0, '0);

    // External write, then CPU reads it back
    set_ext(1, 1, 5'h03, 8'hA5);
    n_we = 0; we_addr = '0;
    repeat (3) begin
      cycle();
      if (s_fr_we) begin n_we++; we_addr = s_addr; end
    end
    check_val("wr_pulses", 32'(n_we), 32'h1);
    check_val("wr_addr", 32'(we_addr), 32'h03);
    set_ext(0, 0, '0, '0);
    set_cpu(0, 1, 0, 5'h03, '0);
    cycle();
    set_cpu(1, 0, 0, '0, '0);
    cycle();
    check_val("cpu_rd_back", 32'(s_frd), 32'hA5);

    // Request during the second cycle of a two-cycle instruction
    set_cpu(0, 1, 0, 5'h0A, '0);
    cycle();
    set_cpu(0, 0, 1, 5'h07, 8'h5A);
    set_ext(1, 0, 5'h03, '0);
    cycle();
    check_val("mid_instr_cpu_en", 32'(s_cpu_en), 32'h1);
    check_val("mid_instr_we", 32'(s_fr_we), 32'h1);
    set_cpu(1, 0, 0, '0, '0);
    cycle();
    check_val("boundary_grant", 32'(s_cpu_en), 32'h0);
    repeat (2) cycle();
    check_val("t3_ack", 32'(s_ack), 32'h1);
    check_val("t3_rdata", 32'(s_rdata), 32'hA5);
    set_ext(0, 0, '0, '0);

    // Continuous requests: burst limit then CPU progress then resume
    set_cpu(0, 0, 0, '0, '0);
    cycle();
    set_cpu(1, 0, 0, '0, '0);
    set_ext(1, 0, 5'h07, '0);
    acks = 0;
    repeat (12) begin cycle(); acks += int'(s_ack); end
    check_val("burst_acks", 32'(acks), 32'd4);
    cycle();
    check_val("burst_hold_cpu_en", 32'(s_cpu_en), 32'h1);
    check_val("burst_hold_ack", 32'(s_ack), 32'h0);
    set_cpu(0, 0, 0, '0, '0);
    cycle();
    set_cpu(1, 0, 0, '0, '0);
    cycle();
    check_val("burst_resume", 32'(s_cpu_en), 32'h0);
    repeat (2) cycle();
    check_val("resume_ack", 32'(s_ack), 32'h1);
    check_val("resume_rdata", 32'(s_rdata), 32'h5A);
    set_ext(0, 0, '0, '0);

    // Reset during an access: no ack, burst allowance restored
    set_cpu(0, 0, 0, '0, '0);
    cycle();
    set_cpu(1, 0, 0, '0, '0);
    set_ext(1, 0, 5'h01, '0);
    repeat (9) cycle();
    cycle();
    check_val("pre_rst_grant", 32'(s_cpu_en), 32'h0);
    rst = 1'b1;
    set_ext(0, 0, '0, '0);
    cycle();
    check_val("rst_cpu_en", 32'(s_cpu_en), 32'h1);
    check_val("rst_ack", 32'(s_ack), 32'h0);
    rst = 1'b0;
    cycle();
    check_val("post_rst_ack", 32'(s_ack), 32'h0);
    check_val("post_rst_cpu_en", 32'(s_cpu_en), 32'h1);
    set_ext(1, 1, 5'h02, 8'hC3);
    acks = 0;
    repeat (12) begin cycle(); acks += int'(s_ack); end
    check_val("post_rst_burst", 32'(acks), 32'd4);
    set_ext(0, 0, '0, '0);

    // Randomized CPU instruction stream and external requester
    cpu_left = 0;
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (cpu_left == 0) set_cpu(1, 0, 0, AW'($urandom), DW'($urandom));
      else begin
        r = int'($urandom_range(0, 2));
        set_cpu(0, r == 1, r == 2, AW'($urandom), DW'($urandom));
      end
      if (!ext_req && $urandom_range(0, 2) == 0)
        set_ext(1, 1'($urandom), AW'($urandom), DW'($urandom));
      cycle();
      if (rst) begin
        cpu_left = 0;
        ext_req  = 0;
      end else begin
        if (e_ack) ext_req = 0;
        if (e_cpu_en) cpu_left = (cpu_left == 0) ? int'($urandom_range(1, 3)) : cpu_left - 1;
      end
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
